// File: rtl/can_bus_responder_pkg.sv
// Shared definitions for the CAN controller bus responder.
//   - default parameter values (synchroniser depth, bank depth, IR/IER addresses)
//   - bus-cycle FSM state encoding
//   - packed bundle of the four synchronised, active-high bus strobes
package can_bus_responder_pkg;

    localparam int         SYNC_STAGES_DEF = 2;
    localparam int         REG_NUM_DEF     = 32;
    localparam logic [7:0] IR_ADDR_DEF     = 8'd3;
    localparam logic [7:0] IER_ADDR_DEF    = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_SEL    = 3'd2,
        ST_READ   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_COMMIT = 3'd5
    } state_e;

    // Bus strobes after synchronisation, all converted to active-high.
    typedef struct packed {
        logic ale;
        logic cs;
        logic rd;
        logic wr;
    } strobe_t;

endpackage

// File: rtl/can_bus_responder_sync_ff.sv
// Multi-stage flop synchroniser for asynchronous bus inputs.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (all stages clear to 0)
//   d_i    in  WIDTH  asynchronous input
//   q_o    out WIDTH  input delayed by DEPTH clocks
// Every bit of a bus passes the same number of stages, so a data bus and its
// strobes synchronised with equal DEPTH stay cycle-aligned to each other.
module can_bus_responder_sync_ff #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[DEPTH-2:0], d_i};
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/can_bus_responder.sv
// Target-side responder for the 8-bit multiplexed Intel-mode CAN controller bus.
// Decodes host address/read/write cycles into a byte register bank, returns
// read data on AD and raises INT_n from locally posted interrupt events.
//   clk, rst_n        clock, asynchronous active-low reset
//   can_ad_i/o/oe     multiplexed AD bus in, read data out, output enable
//   can_ale           address latch enable (active high)
//   can_cs_n/rd_n/wr_n chip select, read and write strobes (active low)
//   can_int_n         interrupt to host (active low)
//   loc_addr_i/wren_i/din_i/dout_o  local register port (dout registered)
//   int_set_i         per-bit pulses ORed into the interrupt register
//   host_wr_o/addr_o/data_o  one-clock notification of a committed host write
module can_bus_responder
    import can_bus_responder_pkg::*;
#(
    parameter int         SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int         REG_NUM     = REG_NUM_DEF,
    parameter logic [7:0] IR_ADDR     = IR_ADDR_DEF,
    parameter logic [7:0] IER_ADDR    = IER_ADDR_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] can_ad_i,
    output logic [7:0] can_ad_o,
    output logic       can_ad_oe,
    input  logic       can_ale,
    input  logic       can_cs_n,
    input  logic       can_rd_n,
    input  logic       can_wr_n,
    output logic       can_int_n,
    input  logic [4:0] loc_addr_i,
    input  logic       loc_wren_i,
    input  logic [7:0] loc_din_i,
    output logic [7:0] loc_dout_o,
    input  logic [7:0] int_set_i,
    output logic       host_wr_o,
    output logic [7:0] host_wr_addr_o,
    output logic [7:0] host_wr_data_o
);

    localparam int             AW      = $clog2(REG_NUM);
    localparam logic [AW-1:0]  IR_IDX  = AW'(IR_ADDR);
    localparam logic [AW-1:0]  IER_IDX = AW'(IER_ADDR);

    // ------------------------------------------------------------------
    // Input synchronisation and edge detection
    // ------------------------------------------------------------------
    logic [7:0] ad_s;
    strobe_t    strb_raw;
    strobe_t    strb_s;
    strobe_t    strb_dly_q;
    strobe_t    strb_dly_d;

    assign strb_raw = {can_ale, ~can_cs_n, ~can_rd_n, ~can_wr_n};

    can_bus_responder_sync_ff #(.WIDTH(8), .DEPTH(SYNC_STAGES)) u_sync_ad (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (can_ad_i),
        .q_o   (ad_s)
    );

    can_bus_responder_sync_ff #(.WIDTH(4), .DEPTH(SYNC_STAGES)) u_sync_strb (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (strb_raw),
        .q_o   (strb_s)
    );

    logic ale_rise;
    logic cs_fall;
    logic rd_fall;
    logic wr_fall;

    assign strb_dly_d = strb_s;
    assign ale_rise   =  strb_s.ale & ~strb_dly_q.ale;
    assign cs_fall    = ~strb_s.cs  &  strb_dly_q.cs;
    assign rd_fall    = ~strb_s.rd  &  strb_dly_q.rd;
    assign wr_fall    = ~strb_s.wr  &  strb_dly_q.wr;

    // ------------------------------------------------------------------
    // Bus-cycle FSM
    // ------------------------------------------------------------------
    state_e state_q;
    state_e state_d;

    // NOTE: every signal written in a combinational block gets a default at
    // the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (ale_rise) begin
            // A new address phase aborts whatever cycle was in progress.
            state_d = ST_ADDR;
        end else begin
            unique case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_ADDR:   if (!strb_s.ale) state_d = ST_SEL;
                ST_SEL: begin
                    if (strb_s.cs && strb_s.rd) begin
                        state_d = ST_READ;
                    end else if (strb_s.cs && strb_s.wr) begin
                        state_d = ST_WRITE;
                    end else if (cs_fall) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_READ:   if (rd_fall || cs_fall) state_d = ST_IDLE;
                ST_WRITE:  if (wr_fall) state_d = ST_COMMIT;
                ST_COMMIT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: address/data latches, register bank, bus and local outputs
    // ------------------------------------------------------------------
    logic [7:0] addr_q,   addr_d;
    logic [7:0] data_q,   data_d;
    logic [7:0] ad_o_q,   ad_o_d;
    logic       oe_q,     oe_d;
    logic       int_n_q,  int_n_d;
    logic [7:0] loc_dout_q, loc_dout_d;
    logic       host_wr_q,  host_wr_d;
    logic [7:0] host_wr_addr_q, host_wr_addr_d;
    logic [7:0] host_wr_data_q, host_wr_data_d;
    logic [7:0] bank_q [REG_NUM];
    logic [7:0] bank_d [REG_NUM];

    logic          addr_ok;
    logic          loc_ok;
    logic [AW-1:0] addr_idx;
    logic [AW-1:0] loc_idx;
    logic [7:0]    rd_data;
    logic          host_commit;
    logic [7:0]    ir_clr;

    assign addr_ok     = 32'(addr_q) < REG_NUM;
    assign loc_ok      = 32'(loc_addr_i) < REG_NUM;
    assign addr_idx    = AW'(addr_q);
    assign loc_idx     = AW'(loc_addr_i);
    assign rd_data     = addr_ok ? bank_q[addr_idx] : 8'h00;
    assign host_commit = (state_q == ST_COMMIT) && addr_ok;

    // IR is read-to-clear: cleared on the cycle the host leaves a read of IR.
    assign ir_clr = ((state_q == ST_READ) && (state_d != ST_READ) && (addr_q == IR_ADDR))
                    ? 8'hFF : 8'h00;

    always_comb begin
        addr_d         = addr_q;
        data_d         = data_q;
        bank_d         = bank_q;
        host_wr_d      = host_commit;
        host_wr_addr_d = host_wr_addr_q;
        host_wr_data_d = host_wr_data_q;

        // Address tracks AD for as long as ALE is high; the last sample is kept.
        if (strb_s.ale) begin
            addr_d = ad_s;
        end

        // Data follows AD while the write strobe is asserted, so the value
        // held is the last one sampled before WR_n returned high.
        if (strb_s.wr && (state_d == ST_WRITE)) begin
            data_d = ad_s;
        end

        // Local write first, host commit second: on an address collision the
        // host value overwrites the local one.
        if (loc_wren_i && loc_ok && (loc_idx != IR_IDX)) begin
            bank_d[loc_idx] = loc_din_i;
        end
        if (host_commit) begin
            host_wr_addr_d = addr_q;
            host_wr_data_d = data_q;
            if (addr_idx != IR_IDX) begin
                bank_d[addr_idx] = data_q;
            end
        end

        // IR is owned by set/clear only; a set arriving with a clear survives.
        bank_d[IR_IDX] = (bank_q[IR_IDX] & ~ir_clr) | int_set_i;

        oe_d       = (state_d == ST_READ);
        ad_o_d     = (state_d == ST_READ) ? rd_data : 8'h00;
        int_n_d    = ~|(bank_q[IR_IDX] & bank_q[IER_IDX]);
        loc_dout_d = loc_ok ? bank_q[loc_idx] : 8'h00;
    end

    // NOTE: the bank is a plain flop array with a full reset; it cannot map
    // to RAM anyway because IR is read-modify-written every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            strb_dly_q     <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            ad_o_q         <= '0;
            oe_q           <= 1'b0;
            int_n_q        <= 1'b1;
            loc_dout_q     <= '0;
            host_wr_q      <= 1'b0;
            host_wr_addr_q <= '0;
            host_wr_data_q <= '0;
            bank_q         <= '{default: '0};
        end else begin
            state_q        <= state_d;
            strb_dly_q     <= strb_dly_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            ad_o_q         <= ad_o_d;
            oe_q           <= oe_d;
            int_n_q        <= int_n_d;
            loc_dout_q     <= loc_dout_d;
            host_wr_q      <= host_wr_d;
            host_wr_addr_q <= host_wr_addr_d;
            host_wr_data_q <= host_wr_data_d;
            bank_q         <= bank_d;
        end
    end

    assign can_ad_o       = ad_o_q;
    assign can_ad_oe      = oe_q;
    assign can_int_n      = int_n_q;
    assign loc_dout_o     = loc_dout_q;
    assign host_wr_o      = host_wr_q;
    assign host_wr_addr_o = host_wr_addr_q;
    assign host_wr_data_o = host_wr_data_q;

endmodule

// File: tb/tb_can_bus_responder.sv
// Directed bench for can_bus_responder. Inputs change on the falling clock
// edge and outputs are sampled on the falling edge, away from the active edge.
module tb_can_bus_responder;

    logic       clk;
    logic       rst_n;
    logic [7:0] can_ad_i;
    logic [7:0] can_ad_o;
    logic       can_ad_oe;
    logic       can_ale;
    logic       can_cs_n;
    logic       can_rd_n;
    logic       can_wr_n;
    logic       can_int_n;
    logic [4:0] loc_addr_i;
    logic       loc_wren_i;
    logic [7:0] loc_din_i;
    logic [7:0] loc_dout_o;
    logic [7:0] int_set_i;
    logic       host_wr_o;
    logic [7:0] host_wr_addr_o;
    logic [7:0] host_wr_data_o;

    int n_compared   = 0;
    int n_mismatched = 0;
    int pulse_cnt    = 0;

    can_bus_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .can_ad_i       (can_ad_i),
        .can_ad_o       (can_ad_o),
        .can_ad_oe      (can_ad_oe),
        .can_ale        (can_ale),
        .can_cs_n       (can_cs_n),
        .can_rd_n       (can_rd_n),
        .can_wr_n       (can_wr_n),
        .can_int_n      (can_int_n),
        .loc_addr_i     (loc_addr_i),
        .loc_wren_i     (loc_wren_i),
        .loc_din_i      (loc_din_i),
        .loc_dout_o     (loc_dout_o),
        .int_set_i      (int_set_i),
        .host_wr_o      (host_wr_o),
        .host_wr_addr_o (host_wr_addr_o),
        .host_wr_data_o (host_wr_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts clock cycles during which host_wr_o was high (old value at the edge).
    always @(posedge clk) begin
        if (host_wr_o === 1'b1) pulse_cnt = pulse_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        can_ale  = 1'b0;
        can_cs_n = 1'b1;
        can_rd_n = 1'b1;
        can_wr_n = 1'b1;
    endtask

    task automatic addr_phase(input logic [7:0] a);
        can_ad_i = a;
        can_ale  = 1'b1;
        can_cs_n = 1'b0;
        repeat (3) @(negedge clk);
        can_ale  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d, input bit collide,
                              input logic [4:0] la, input logic [7:0] ld);
        addr_phase(a);
        can_ad_i = d;
        can_wr_n = 1'b0;
        repeat (4) @(negedge clk);
        can_wr_n = 1'b1;
        repeat (3) @(negedge clk);
        // Now inside the COMMIT cycle.
        if (collide) begin
            loc_addr_i = la;
            loc_din_i  = ld;
            loc_wren_i = 1'b1;
        end
        @(negedge clk);
        loc_wren_i = 1'b0;
        can_cs_n   = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic host_read(input logic [7:0] a, input logic [7:0] set_on_clr,
                             output logic oe_early, output logic oe_on, output logic [7:0] dat,
                             output logic oe_hold, output logic oe_off);
        addr_phase(a);
        can_rd_n = 1'b0;
        repeat (2) @(negedge clk);
        oe_early = can_ad_oe;
        @(negedge clk);
        oe_on = can_ad_oe;
        dat   = can_ad_o;
        repeat (2) @(negedge clk);
        can_rd_n = 1'b1;
        repeat (2) @(negedge clk);
        // rd_s has just fallen: this is the IR clear cycle.
        oe_hold   = can_ad_oe;
        int_set_i = set_on_clr;
        @(negedge clk);
        int_set_i = 8'h00;
        oe_off    = can_ad_oe;
        can_cs_n  = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic loc_write(input logic [4:0] a, input logic [7:0] v);
        loc_addr_i = a;
        loc_din_i  = v;
        loc_wren_i = 1'b1;
        @(negedge clk);
        loc_wren_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic loc_read(input logic [4:0] a, output logic [7:0] d);
        loc_addr_i = a;
        @(negedge clk);
        d = loc_dout_o;
    endtask

    logic       oe_e, oe_n, oe_h, oe_f;
    logic [7:0] rdat;
    logic [7:0] ldat;
    int         pc0;

    initial begin
        rst_n      = 1'b0;
        can_ad_i   = 8'h00;
        loc_addr_i = 5'h00;
        loc_wren_i = 1'b0;
        loc_din_i  = 8'h00;
        int_set_i  = 8'h00;
        bus_idle();

        // Reset state
        #12;
        check("rst_ad_o",      can_ad_o,          8'h00);
        check("rst_oe",        8'(can_ad_oe),     8'h00);
        check("rst_int_n",     8'(can_int_n),     8'h01);
        check("rst_loc_dout",  loc_dout_o,        8'h00);
        check("rst_host_wr",   8'(host_wr_o),     8'h00);
        check("rst_wr_addr",   host_wr_addr_o,    8'h00);
        check("rst_wr_data",   host_wr_data_o,    8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Host write 0x05 = 0xA5
        host_write(8'h05, 8'hA5, 1'b0, 5'h00, 8'h00);
        check("wr1_pulses",    8'(pulse_cnt),     8'd1);
        check("wr1_addr",      host_wr_addr_o,    8'h05);
        check("wr1_data",      host_wr_data_o,    8'hA5);
        loc_read(5'h05, ldat);
        check("wr1_loc_rd",    ldat,              8'hA5);

        // Local write 0x0A = 0x3C, host read back with oe timing
        loc_write(5'h0A, 8'h3C);
        host_read(8'h0A, 8'h00, oe_e, oe_n, rdat, oe_h, oe_f);
        check("rd_oe_early",   8'(oe_e),          8'h00);
        check("rd_oe_on",      8'(oe_n),          8'h01);
        check("rd_data",       rdat,              8'h3C);
        check("rd_oe_hold",    8'(oe_h),          8'h01);
        check("rd_oe_off",     8'(oe_f),          8'h00);

        // Interrupt: IER = 0x01, post bit 0
        loc_write(5'h04, 8'h01);
        check("int_idle",      8'(can_int_n),     8'h01);
        int_set_i = 8'h01;
        @(negedge clk);
        int_set_i = 8'h00;
        check("int_latency",   8'(can_int_n),     8'h01);
        @(negedge clk);
        check("int_asserted",  8'(can_int_n),     8'h00);

        // Read IR (clears it); bit 1 posted in the clear cycle survives
        host_read(8'h03, 8'h02, oe_e, oe_n, rdat, oe_h, oe_f);
        check("ir_rd_data",    rdat,              8'h01);
        check("ir_int_clear",  8'(can_int_n),     8'h01);
        loc_read(5'h03, ldat);
        check("ir_set_wins",   ldat,              8'h02);

        // Host and local writes to IR are ignored
        host_write(8'h03, 8'hFF, 1'b0, 5'h00, 8'h00);
        loc_write(5'h03, 8'h00);
        loc_read(5'h03, ldat);
        check("ir_wr_ignored", ldat,              8'h02);

        // Out-of-range address: no commit, reads 0x00
        pc0 = pulse_cnt;
        host_write(8'h40, 8'h77, 1'b0, 5'h00, 8'h00);
        check("oor_no_pulse",  8'(pulse_cnt - pc0), 8'd0);
        host_read(8'h40, 8'h00, oe_e, oe_n, rdat, oe_h, oe_f);
        check("oor_oe",        8'(oe_n),          8'h01);
        check("oor_rd_data",   rdat,              8'h00);

        // Same-clock host commit and local write to 0x07: host wins
        pc0 = pulse_cnt;
        host_write(8'h07, 8'h11, 1'b1, 5'h07, 8'h22);
        check("col_pulse",     8'(pulse_cnt - pc0), 8'd1);
        loc_read(5'h07, ldat);
        check("col_same_addr", ldat,              8'h11);

        // Same-clock commit to 0x08 and local write to 0x09: both apply
        host_write(8'h08, 8'h55, 1'b1, 5'h09, 8'h66);
        loc_read(5'h08, ldat);
        check("col_host_08",   ldat,              8'h55);
        loc_read(5'h09, ldat);
        check("col_loc_09",    ldat,              8'h66);

        // IER = 0x03 so IR bit 1 drives INT_n low
        loc_write(5'h04, 8'h03);
        check("int_ier3",      8'(can_int_n),     8'h00);

        // ALE re-asserted during a write to 0x0B aborts it; then read 0x0A
        pc0 = pulse_cnt;
        addr_phase(8'h0B);
        can_ad_i = 8'h99;
        can_wr_n = 1'b0;
        repeat (4) @(negedge clk);
        can_ad_i = 8'h0A;
        can_ale  = 1'b1;
        repeat (3) @(negedge clk);
        can_wr_n = 1'b1;
        repeat (3) @(negedge clk);
        can_ale  = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_pulse", 8'(pulse_cnt - pc0), 8'd0);
        loc_read(5'h0B, ldat);
        check("abort_no_write", ldat,             8'h00);
        can_rd_n = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_rd_oe",   8'(can_ad_oe),     8'h01);
        check("abort_rd_data", can_ad_o,          8'h3C);

        // Reset in the middle of the read releases the bus immediately
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_oe",     8'(can_ad_oe),     8'h00);
        check("midrst_ad_o",   can_ad_o,          8'h00);
        check("midrst_int_n",  8'(can_int_n),     8'h01);
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        loc_read(5'h0A, ldat);
        check("midrst_bank",   ldat,              8'h00);
        check("midrst_wr_addr", host_wr_addr_o,   8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
